// File: rtl/bf_run_controller.sv
// bf_run_controller: sequences a brainfuck core through program load, array clear, run and done
module bf_run_controller #(
  parameter int addrSize_code  = 9,
  parameter int addrSize_array = 9
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  input  logic                      reload,
  output logic                      core_reset,
  input  logic [addrSize_code-1:0]  core_addr_code,
  input  logic                      core_done,
  output logic                      core_rx_valid,
  output logic [7:0]                core_rx_data,
  output logic [addrSize_code-1:0]  code_addr,
  output logic                      code_we,
  output logic [7:0]                code_wdata,
  input  logic [addrSize_array-1:0] core_addr_arr,
  input  logic                      core_we_arr,
  input  logic [7:0]                core_dout_arr,
  output logic [addrSize_array-1:0] arr_addr,
  output logic                      arr_we,
  output logic [7:0]                arr_wdata,
  output logic [1:0]                state,
  output logic                      overflow
);
  typedef enum logic [1:0] {LOAD, CLEAR, RUN, DONE} state_t;
  state_t                      st;
  logic [addrSize_code-1:0]    load_ptr;
  logic [addrSize_code-1:0]    wr_addr;
  logic [addrSize_array-1:0]   clr_ptr;
  logic                        full;
  logic                        trunc;
  assign full  = &load_ptr;
  assign trunc = full && rx_data != 8'h00;
  // Sequencer: program bytes land in code RAM one cycle after they arrive; the last
  // slot is forced to a null terminator when the program does not fit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      st         <= LOAD;
      load_ptr   <= '0;
      wr_addr    <= '0;
      clr_ptr    <= '0;
      code_we    <= 1'b0;
      code_wdata <= 8'h00;
      core_reset <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      code_we <= 1'b0;
      if (reload && st != LOAD) begin
        st         <= LOAD;
        core_reset <= 1'b0;
        load_ptr   <= '0;
        clr_ptr    <= '0;
        overflow   <= 1'b0;
      end else begin
        case (st)
          LOAD: if (rx_valid) begin
            code_we    <= 1'b1;
            wr_addr    <= load_ptr;
            load_ptr   <= load_ptr + 1'b1;
            code_wdata <= trunc ? 8'h00 : rx_data;
            if (trunc) overflow <= 1'b1;
            if (full || rx_data == 8'h00) st <= CLEAR;
          end
          CLEAR: begin
            clr_ptr <= clr_ptr + 1'b1;
            if (&clr_ptr) begin
              st         <= RUN;
              core_reset <= 1'b1;
            end
          end
          RUN: if (core_done) st <= DONE;
          default: ;
        endcase
      end
    end
  end
  // RAM muxes: the pending load write owns the code port for its one cycle,
  // the clearer owns the array port for all of CLEAR.
  always_comb begin
    code_addr     = code_we ? wr_addr : (st == LOAD ? load_ptr : core_addr_code);
    arr_addr      = st == CLEAR ? clr_ptr : core_addr_arr;
    arr_we        = st == CLEAR ? 1'b1 : core_we_arr;
    arr_wdata     = st == CLEAR ? 8'h00 : core_dout_arr;
    core_rx_valid = rx_valid && st == RUN;
    core_rx_data  = rx_data;
    state         = st;
  end
endmodule
